vdc_pixelgen: RTL and testbench

Pixel serializer for the C128 VDC, directly downstream of the VDC RAM interface. Each display column, the RAM-interface stage pushes one entry: character/bitmap byte, attribute byte and per-column flags. The entry passes through a small FIFO. It is then shifted out at dot rate as 4-bit RGBI pixels, with attribute decoding (reverse, underline, blink, foreground colour) and intercharacter-gap handling applied.

---
 rtl/vdc_pixelgen.sv | 228 ++++++++++++++++++++++
 tb/tb_vdc_pixelgen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_pixelgen.sv
// vdc_pixelgen -- C128 VDC pixel serializer.
//
// Sits directly downstream of the VDC RAM interface. Each column entry
// {char, attr, disp, cursor, last} is queued in a small FIFO. It is then
// shifted out at dot rate as 4-bit RGBI pixels, with attribute decoding
// (blink, underline, reverse, foreground colour) and intercharacter-gap
// handling applied.
//
// Optional feature macro: VDC_SEMIGRAPHICS_EN
//   defined   : reg_semi repeats char[0] into gap / beyond-8 pixels
//   undefined : reg_semi is ignored; those pixels are always base 0
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   dot_en                pixel-rate clock enable (state advances only here)
//   load, load_*          column push strobe and entry fields
//   reg_*                 live VDC register values, sampled on every dot_en
//   line, blink_phase     current scanline in row, blink hide phase
//   full                  FIFO count == FIFO_DEPTH
//   pix, pix_vis          registered pixel colour and display-data flag
//   underflow, overflow   sticky error flags, cleared only by reset
module vdc_pixelgen #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       load,
    input  logic [7:0] load_char,
    input  logic [7:0] load_attr,
    input  logic       load_disp,
    input  logic       load_cursor,
    input  logic       load_last,
    input  logic [3:0] reg_cth,
    input  logic [3:0] reg_cdh,
    input  logic       reg_semi,
    input  logic       reg_text,
    input  logic       reg_atr,
    input  logic       reg_rvs,
    input  logic [3:0] reg_fg,
    input  logic [3:0] reg_bg,
    input  logic [4:0] reg_ul,
    input  logic [4:0] line,
    input  logic       blink_phase,
    output logic       full,
    output logic [3:0] pix,
    output logic       pix_vis,
    output logic       underflow,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [7:0] chr;
        logic [7:0] attr;
        logic       disp;
        logic       cursor;
        logic       last;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // ---------------- entry FIFO ----------------
    entry_t          mem [FIFO_DEPTH];
    entry_t          wr_entry;
    entry_t          rd_entry;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;
    logic            fifo_empty;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Push is gated on the registered full, so a load into a full FIFO is
    // dropped even when a pop frees a slot in the same cycle.
    assign push       = load & ~full;
    assign wr_entry   = {load_char, load_attr, load_disp, load_cursor, load_last};
    assign rd_entry   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (load && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- pixel function ----------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] px_q;
    logic [3:0] px_d;
    entry_t     cur_q;
    logic [3:0] pix_d;
    logic       vis_d;
    logic       uf_set;

    logic       gap_bit;
    logic       pbit;
    logic       attr_text;
    logic [3:0] fg;
    logic [3:0] cell_pix;
    logic       cell_vis;
    logic       unused_bits;

`ifdef VDC_SEMIGRAPHICS_EN
    assign gap_bit     = reg_semi & cur_q.chr[0];
    assign unused_bits = cur_q.attr[7];
`else
    assign gap_bit     = 1'b0;
    assign unused_bits = cur_q.attr[7] ^ reg_semi;
`endif

    always_comb begin
        pbit      = gap_bit;
        attr_text = reg_atr & ~reg_text;
        if ((px_q <= reg_cdh) && (px_q < 4'd8)) begin
            pbit = cur_q.chr[3'd7 - px_q[2:0]];
        end
        if (attr_text && cur_q.attr[4] && blink_phase) begin
            pbit = 1'b0;
        end
        if (attr_text && cur_q.attr[5] && (line == reg_ul)) begin
            pbit = 1'b1;
        end
        pbit = pbit ^ ((reg_atr & cur_q.attr[6]) ^ reg_rvs ^ cur_q.cursor);
        fg   = reg_atr ? cur_q.attr[3:0] : reg_fg;
        if (cur_q.disp) begin
            cell_pix = pbit ? fg : reg_bg;
            cell_vis = 1'b1;
        end else begin
            cell_pix = reg_bg;
            cell_vis = 1'b0;
        end
    end

    // ---------------- serializer FSM ----------------
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        pix_d   = pix;
        vis_d   = pix_vis;
        pop     = 1'b0;
        uf_set  = 1'b0;
        if (dot_en) begin
            case (state_q)
                S_IDLE: begin
                    pix_d = reg_bg;
                    vis_d = 1'b0;
                    px_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    pix_d = cell_pix;
                    vis_d = cell_vis;
                    // >= so a live shrink of reg_cth below px ends the cell now
                    if (px_q >= reg_cth) begin
                        px_d = '0;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            uf_set  = ~cur_q.last;
                        end
                    end else begin
                        px_d = px_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            px_q      <= '0;
            cur_q     <= '0;
            pix       <= '0;
            pix_vis   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            pix     <= pix_d;
            pix_vis <= vis_d;
            if (pop) begin
                cur_q <= rd_entry;
            end
            if (uf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vdc_pixelgen.sv
module tb_vdc_pixelgen;

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en;
    logic       load;
    logic [7:0] load_char;
    logic [7:0] load_attr;
    logic       load_disp;
    logic       load_cursor;
    logic       load_last;
    logic [3:0] reg_cth;
    logic [3:0] reg_cdh;
    logic       reg_semi;
    logic       reg_text;
    logic       reg_atr;
    logic       reg_rvs;
    logic [3:0] reg_fg;
    logic [3:0] reg_bg;
    logic [4:0] reg_ul;
    logic [4:0] line;
    logic       blink_phase;
    logic       full;
    logic [3:0] pix;
    logic       pix_vis;
    logic       underflow;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vdc_pixelgen #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .load(load),
        .load_char(load_char), .load_attr(load_attr), .load_disp(load_disp),
        .load_cursor(load_cursor), .load_last(load_last),
        .reg_cth(reg_cth), .reg_cdh(reg_cdh), .reg_semi(reg_semi),
        .reg_text(reg_text), .reg_atr(reg_atr), .reg_rvs(reg_rvs),
        .reg_fg(reg_fg), .reg_bg(reg_bg), .reg_ul(reg_ul), .line(line),
        .blink_phase(blink_phase), .full(full), .pix(pix),
        .pix_vis(pix_vis), .underflow(underflow), .overflow(overflow)
    );

    // Expected pixels: hex digit i (from the left) of exp is pixel i.
    typedef struct {
        logic [7:0]  chr;
        logic [7:0]  attr;
        logic [3:0]  cth;
        logic [3:0]  cdh;
        logic        semi;
        logic        text;
        logic        atr;
        logic        rvs;
        logic [3:0]  fg;
        logic [3:0]  bg;
        logic [4:0]  ul;
        logic [4:0]  line;
        logic        blink;
        logic        disp;
        logic        cursor;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic dot();
        @(negedge clk);
        dot_en = 1'b1;
        @(posedge clk);
        #1;
        dot_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        dot_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] a, input logic d,
                        input logic cur, input logic last, input logic de);
        @(negedge clk);
        load        = 1'b1;
        load_char   = c;
        load_attr   = a;
        load_disp   = d;
        load_cursor = cur;
        load_last   = last;
        dot_en      = de;
        @(posedge clk);
        #1;
        load   = 1'b0;
        dot_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        load   = 1'b0;
        dot_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic vec_t plain(input logic [7:0] c, input logic [63:0] e);
        vec_t v;
        v.chr = c;      v.attr = 8'h00;  v.cth = 4'd7;  v.cdh = 4'd7;
        v.semi = 1'b0;  v.text = 1'b0;   v.atr = 1'b0;  v.rvs = 1'b0;
        v.fg = 4'h1;    v.bg = 4'h0;     v.ul = 5'd3;   v.line = 5'd0;
        v.blink = 1'b0; v.disp = 1'b1;   v.cursor = 1'b0;
        v.exp = e;
        return v;
    endfunction

    task automatic set_regs(input vec_t v);
        reg_cth = v.cth;  reg_cdh = v.cdh;  reg_semi = v.semi; reg_text = v.text;
        reg_atr = v.atr;  reg_rvs = v.rvs;  reg_fg = v.fg;     reg_bg = v.bg;
        reg_ul = v.ul;    line = v.line;    blink_phase = v.blink;
    endtask

    logic [3:0]  hold_pix;
    logic [7:0]  ov_chars [5];
    logic [3:0]  exp_px;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; dot_en = 1'b0; load = 1'b0;
        load_char = '0; load_attr = '0; load_disp = 1'b0; load_cursor = 1'b0; load_last = 1'b0;
        set_regs(plain(8'h00, 64'h0));

        // ---- vector table ----
        vecs[0] = plain(8'hA5, 64'h1010_0101_0000_0000);
        vecs[1] = plain(8'h81, 64'h0);
        vecs[1].cth = 4'd9; vecs[1].semi = 1'b1; vecs[1].fg = 4'h3;
`ifdef VDC_SEMIGRAPHICS_EN
        vecs[1].exp = 64'h3000_0003_3300_0000;
`else
        vecs[1].exp = 64'h3000_0003_0000_0000;
`endif
        vecs[2] = vecs[1];
        vecs[2].semi = 1'b0; vecs[2].exp = 64'h3000_0003_0000_0000;
        vecs[3] = plain(8'h00, 64'h2222_2222_0000_0000);
        vecs[3].atr = 1'b1; vecs[3].attr = 8'h65; vecs[3].line = 5'd3; vecs[3].fg = 4'hF; vecs[3].bg = 4'h2;
        vecs[4] = vecs[3];
        vecs[4].line = 5'd4; vecs[4].exp = 64'h5555_5555_0000_0000;
        vecs[5] = plain(8'hFF, 64'h0);
        vecs[5].text = 1'b1; vecs[5].atr = 1'b1; vecs[5].attr = 8'h30; vecs[5].blink = 1'b1;
        vecs[5].line = 5'd3; vecs[5].bg = 4'hE;
        vecs[6] = plain(8'hFF, 64'h1111_1111_0000_0000);
        vecs[6].atr = 1'b1; vecs[6].attr = 8'h1A; vecs[6].blink = 1'b1; vecs[6].bg = 4'h1;
        vecs[7] = plain(8'hF0, 64'h0000_7777_0000_0000);
        vecs[7].cursor = 1'b1; vecs[7].fg = 4'h7;
        vecs[8] = plain(8'hFF, 64'h4444_4444_0000_0000);
        vecs[8].disp = 1'b0; vecs[8].bg = 4'h4; vecs[8].rvs = 1'b1; vecs[8].cursor = 1'b1;
        vecs[9] = plain(8'h3C, 64'h6600_6600_0000_0000);
        vecs[9].rvs = 1'b1; vecs[9].fg = 4'h6; vecs[9].cth = 4'd5; vecs[9].cdh = 4'd3;
        vecs[10] = plain(8'h01, 64'h0);
        vecs[10].cth = 4'd11; vecs[10].cdh = 4'd11; vecs[10].semi = 1'b1; vecs[10].fg = 4'h9;
`ifdef VDC_SEMIGRAPHICS_EN
        vecs[10].exp = 64'h0000_0009_9999_0000;
`else
        vecs[10].exp = 64'h0000_0009_0000_0000;
`endif

        // ---- reset state ----
        do_reset();
        chk("reset_pix", 32'(pix), 32'h0);
        chk("reset_vis", 32'(pix_vis), 32'h0);
        chk("reset_full", 32'(full), 32'h0);
        chk("reset_underflow", 32'(underflow), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);

        // ---- table-driven single cells ----
        for (int v = 0; v < 11; v++) begin
            do_reset();
            set_regs(vecs[v]);
            push(vecs[v].chr, vecs[v].attr, vecs[v].disp, vecs[v].cursor, 1'b1, 1'b0);
            dot();
            chk($sformatf("v%0d_pop_vis", v), 32'(pix_vis), 32'h0);
            for (int i = 0; i <= int'(vecs[v].cth); i++) begin
                dot();
                chk($sformatf("v%0d_pix%0d", v, i), 32'(pix), 32'(vecs[v].exp[63-4*i -: 4]));
                chk($sformatf("v%0d_vis%0d", v, i), 32'(pix_vis), 32'(vecs[v].disp));
                if (i == 2) begin
                    hold_pix = pix;
                    idle_cycle();
                    chk($sformatf("v%0d_hold", v), 32'(pix), 32'(hold_pix));
                end
            end
            dot();
            chk($sformatf("v%0d_idle_pix", v), 32'(pix), 32'(vecs[v].bg));
            chk($sformatf("v%0d_idle_vis", v), 32'(pix_vis), 32'h0);
            chk($sformatf("v%0d_underflow", v), 32'(underflow), 32'h0);
        end

        // ---- overflow: five pushes with dot_en low, then a load during the pop dot ----
        do_reset();
        set_regs(plain(8'h00, 64'h0));
        ov_chars[0] = 8'h80; ov_chars[1] = 8'h40; ov_chars[2] = 8'h20;
        ov_chars[3] = 8'h10; ov_chars[4] = 8'h08;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ov_full_before%0d", k), 32'(full), 32'h0);
            push(ov_chars[k], 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("ov_full_after4", 32'(full), 32'h1);
        chk("ov_flag_after4", 32'(overflow), 32'h0);
        push(ov_chars[4], 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ov_flag_after5", 32'(overflow), 32'h1);
        chk("ov_full_after5", 32'(full), 32'h1);
        push(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);   // pop dot + load while full
        chk("ov_full_after_pop", 32'(full), 32'h0);
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 8; p++) begin
                dot();
                exp_px = (p == c) ? 4'h1 : 4'h0;
                chk($sformatf("ov_c%0d_p%0d", c, p), 32'(pix), 32'(exp_px));
            end
        end
        dot();
        chk("ov_end_vis", 32'(pix_vis), 32'h0);
        chk("ov_end_underflow", 32'(underflow), 32'h0);

        // ---- underflow: two non-last cells, no further pushes ----
        do_reset();
        set_regs(plain(8'h00, 64'h0));
        reg_cth = 4'd3; reg_cdh = 4'd3; reg_bg = 4'h2;
        push(8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        dot();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                dot();
                exp_px = (p < 2) ? 4'h1 : 4'h2;
                chk($sformatf("uf_c%0d_p%0d", c, p), 32'(pix), 32'(exp_px));
            end
            chk($sformatf("uf_flag_c%0d", c), 32'(underflow), (c == 1) ? 32'h1 : 32'h0);
        end
        dot();
        chk("uf_idle_vis", 32'(pix_vis), 32'h0);
        chk("uf_idle_pix", 32'(pix), 32'h2);
        dot();
        chk("uf_sticky", 32'(underflow), 32'h1);
        do_reset();
        chk("uf_cleared", 32'(underflow), 32'h0);
        chk("uf_reset_pix", 32'(pix), 32'h0);

        // ---- live reg_cth shrink ends the cell on the next dot ----
        do_reset();
        set_regs(plain(8'h00, 64'h0));
        push(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        dot();
        for (int p = 0; p < 4; p++) dot();
        reg_cth = 4'd1;
        dot();
        chk("cth_last_pix", 32'(pix), 32'h1);
        chk("cth_last_vis", 32'(pix_vis), 32'h1);
        dot();
        chk("cth_idle_vis", 32'(pix_vis), 32'h0);
        chk("cth_underflow", 32'(underflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
